// File: rtl/mpy_share_ctrl_if.sv
// Purpose : bundle of requester handshake, multiplier operand/product and response signals for mpy_share_ctrl.
// Latency : none, wires only.
// Backpressure: req_valid/req_ready per requester; the response path has none (resp_valid is a pulse).
//
// Ports (signals):
//   req_valid[N_REQ], req_a[4*N_REQ], req_b[4*N_REQ] : requester operands, 4-bit signed, packed per requester
//   req_ready[N_REQ]                                  : one-hot grant back to the requesters
//   mpy_a[4], mpy_b[4], mpy_product[8]                : link to the external sequential multiplier
//   resp_valid[N_REQ], resp_product[8]                : one-hot one-cycle result pulse and signed result
//   busy                                              : an operation is in flight
// Modports: slave = the controller; master = the requesters plus multiplier environment around it.
interface mpy_share_ctrl_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]   req_valid;
   logic [4*N_REQ-1:0] req_a;
   logic [4*N_REQ-1:0] req_b;
   logic [N_REQ-1:0]   req_ready;
   logic [3:0]         mpy_a;
   logic [3:0]         mpy_b;
   logic [7:0]         mpy_product;
   logic [N_REQ-1:0]   resp_valid;
   logic [7:0]         resp_product;
   logic               busy;

   modport slave (
      input  req_valid, req_a, req_b, mpy_product,
      output req_ready, mpy_a, mpy_b, resp_valid, resp_product, busy
   );

   modport master (
      output req_valid, req_a, req_b, mpy_product,
      input  req_ready, mpy_a, mpy_b, resp_valid, resp_product, busy
   );
endinterface

// File: rtl/mpy_share_ctrl.sv
// Purpose : round-robin sharing of one external sequential 4x4 signed multiplier among N_REQ requesters.
// Latency : response pulse MPY_LAT edges after the grant edge; one operation per MPY_LAT+2 cycles.
// Backpressure: one-hot req_ready only in IDLE; responses cannot be stalled, requesters must take the pulse.
//
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : mpy_share_ctrl_if.slave (requester handshakes, multiplier operands/product, response, busy)
module mpy_share_ctrl #(
   parameter int N_REQ   = 4,
   parameter int MPY_LAT = 16
) (
   input  logic             clk,
   input  logic             rst,
   mpy_share_ctrl_if.slave  bus
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = (MPY_LAT > 1) ? $clog2(MPY_LAT) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(MPY_LAT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [PW-1:0]     ptr_q;
   logic [PW-1:0]     gnt_q;
   logic [CW-1:0]     cnt_q;
   logic [3:0]        mpy_a_q;
   logic [3:0]        mpy_b_q;
   logic [7:0]        resp_product_q;
   logic [N_REQ-1:0]  resp_valid_q;

   logic              win_found;
   logic [PW-1:0]     win_idx;
   logic [N_REQ-1:0]  req_ready_c;
   logic              hs;

   // (base + off) mod N_REQ; off never exceeds N_REQ-1, so one conditional
   // subtract is enough and non-power-of-two requester counts still wrap.
   function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= N_REQ) begin
         s = s - N_REQ;
      end
      return PW'(s);
   endfunction

   // Winner search starting at the priority pointer. The first valid
   // requester found is kept; later ones are ignored.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!win_found && bus.req_valid[rr_idx(ptr_q, k)]) begin
            win_found = 1'b1;
            win_idx   = rr_idx(ptr_q, k);
         end
      end
   end

   // Next state and grant. In IDLE a grant is only ever given to a requester
   // that is currently valid, so a grant is always a handshake.
   always_comb begin
      state_d     = state_q;
      req_ready_c = '0;
      hs          = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (win_found) begin
               req_ready_c[win_idx] = 1'b1;
               hs                   = 1'b1;
               state_d              = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath. Operands are captured only on the handshake edge and then
   // held, so requester-side changes during WAIT never reach the multiplier.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q          <= '0;
         gnt_q          <= '0;
         cnt_q          <= '0;
         mpy_a_q        <= '0;
         mpy_b_q        <= '0;
         resp_product_q <= '0;
         resp_valid_q   <= '0;
      end else begin
         resp_valid_q <= '0;
         if (hs) begin
            mpy_a_q <= bus.req_a[4*int'(win_idx) +: 4];
            mpy_b_q <= bus.req_b[4*int'(win_idx) +: 4];
            gnt_q   <= win_idx;
            cnt_q   <= CNT_LOAD;
            ptr_q   <= rr_idx(win_idx, 1);
         end
         if (state_q == WAIT) begin
            if (cnt_q == '0) begin
               // Product has been stable for MPY_LAT cycles of held operands.
               resp_product_q      <= bus.mpy_product;
               resp_valid_q[gnt_q] <= 1'b1;
            end else begin
               cnt_q <= cnt_q - CW'(1);
            end
         end
      end
   end

   assign bus.req_ready    = req_ready_c;
   assign bus.mpy_a        = mpy_a_q;
   assign bus.mpy_b        = mpy_b_q;
   assign bus.resp_valid   = resp_valid_q;
   assign bus.resp_product = resp_product_q;
   assign bus.busy         = (state_q != IDLE);

   a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.req_ready));
   a_resp_onehot:  assert property (@(posedge clk) disable iff (rst) $onehot0(bus.resp_valid));
   a_ready_valid:  assert property (@(posedge clk) disable iff (rst)
                                    ((bus.req_ready & ~bus.req_valid) == '0));

endmodule

// File: tb/tb_mpy_share_ctrl.sv
// Purpose : directed self-checking bench for mpy_share_ctrl with a behavioural latency-aware multiplier.
// Latency : n/a.
// Backpressure: n/a.
module tb_mpy_share_ctrl;
   localparam int N = 4;
   localparam int L = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mpy_share_ctrl_if #(.N_REQ(N)) bus ();

   mpy_share_ctrl #(.N_REQ(N), .MPY_LAT(L)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Multiplier model: the product is only correct once operands have been
   // held for L-1 edges after the grant edge; before that it shows garbage.
   int hold = 255;
   logic signed [7:0] true_prod;
   always @(posedge clk) begin
      if (!rst && |(bus.req_ready & bus.req_valid)) hold <= 0;
      else if (hold < 255) hold <= hold + 1;
   end
   assign true_prod = $signed({{4{bus.mpy_a[3]}}, bus.mpy_a}) * $signed({{4{bus.mpy_b[3]}}, bus.mpy_b});
   assign bus.mpy_product = (hold >= L - 1) ? true_prod : 8'hA5;

   // Event logs sampled on the falling edge. hs.ed = edge the handshake fires
   // on; rsp.ed = edge that raised resp_valid.
   typedef struct { int idx; int ed; } ev_t;
   typedef struct { logic [N-1:0] vec; logic [7:0] prod; int ed; } rsp_t;
   ev_t  hs_q[$];
   rsp_t rsp_q[$];
   int   busy_cnt = 0;

   function automatic int oh_idx(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   always @(negedge clk) begin
      ev_t  e;
      rsp_t r;
      if (!rst) begin
         if (|(bus.req_ready & bus.req_valid)) begin
            e.idx = oh_idx(bus.req_ready);
            e.ed  = cyc + 1;
            hs_q.push_back(e);
         end
         if (|bus.resp_valid) begin
            r.vec  = bus.resp_valid;
            r.prod = bus.resp_product;
            r.ed   = cyc;
            rsp_q.push_back(r);
         end
         if (bus.busy) busy_cnt <= busy_cnt + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.req_valid = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b);
      bus.req_a[4*i +: 4] = a;
      bus.req_b[4*i +: 4] = b;
      bus.req_valid[i]    = 1'b1;
   endtask

   // Wait for the next grant and drop that requester's valid right after it.
   task automatic serve_one();
      logic [N-1:0] g;
      g = '0;
      for (int k = 0; k < 200 && g == '0; k++) begin
         @(negedge clk);
         g = bus.req_ready & bus.req_valid;
      end
      @(posedge clk);
      #1;
      bus.req_valid = bus.req_valid & ~g;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.req_valid = '0;
      bus.req_a = '0;
      bus.req_b = '0;
      tick();
      tick();
      tests++; if (bus.req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready); end
      tests++; if (bus.mpy_a !== 4'h0) begin fails++; $display("FAIL reset_mpy_a: got %h want 0", bus.mpy_a); end
      tests++; if (bus.mpy_b !== 4'h0) begin fails++; $display("FAIL reset_mpy_b: got %h want 0", bus.mpy_b); end
      tests++; if (bus.resp_valid !== 4'b0000) begin fails++; $display("FAIL reset_resp_valid: got %b want 0000", bus.resp_valid); end
      tests++; if (bus.resp_product !== 8'h00) begin fails++; $display("FAIL reset_resp_product: got %h want 00", bus.resp_product); end
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      int h0, r0, b0;
      h0 = hs_q.size(); r0 = rsp_q.size(); b0 = busy_cnt;
      set_req(0, 4'd3, 4'hE);
      #1;
      tests++; if (bus.req_ready !== 4'b0001) begin fails++; $display("FAIL single_ready: got %b want 0001", bus.req_ready); end
      serve_one();
      tests++; if (bus.mpy_a !== 4'd3) begin fails++; $display("FAIL single_mpy_a: got %h want 3", bus.mpy_a); end
      tests++; if (bus.mpy_b !== 4'hE) begin fails++; $display("FAIL single_mpy_b: got %h want e", bus.mpy_b); end
      tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL single_busy_rise: got %b want 1", bus.busy); end
      repeat (22) tick();
      tests++;
      if (hs_q.size() != h0 + 1 || rsp_q.size() != r0 + 1) begin
         fails++; $display("FAIL single_counts: got hs=%0d rsp=%0d want 1 1", hs_q.size() - h0, rsp_q.size() - r0);
      end else begin
         tests++; if (hs_q[h0].idx != 0) begin fails++; $display("FAIL single_hs_idx: got %0d want 0", hs_q[h0].idx); end
         tests++; if (rsp_q[r0].vec !== 4'b0001) begin fails++; $display("FAIL single_resp_vec: got %b want 0001", rsp_q[r0].vec); end
         tests++; if (rsp_q[r0].prod !== 8'hFA) begin fails++; $display("FAIL single_prod: got %h want fa", rsp_q[r0].prod); end
         tests++; if (rsp_q[r0].ed - hs_q[h0].ed != 16) begin fails++; $display("FAIL single_latency: got %0d want 16", rsp_q[r0].ed - hs_q[h0].ed); end
      end
      tests++; if (busy_cnt - b0 != 17) begin fails++; $display("FAIL single_busy_len: got %0d want 17", busy_cnt - b0); end
   endtask

   task automatic test_extremes();
      logic [3:0] va [4] = '{4'h8, 4'h8, 4'h7, 4'h0};
      logic [3:0] vb [4] = '{4'h8, 4'h7, 4'h7, 4'hB};
      logic [7:0] vp [4] = '{8'h40, 8'hC8, 8'h31, 8'h00};
      for (int j = 0; j < 4; j++) begin
         int r0;
         logic [N-1:0] want;
         r0 = rsp_q.size();
         want = '0;
         want[(j + 1) % N] = 1'b1;
         set_req((j + 1) % N, va[j], vb[j]);
         serve_one();
         repeat (19) tick();
         tests++;
         if (rsp_q.size() != r0 + 1) begin
            fails++; $display("FAIL extreme_count[%0d]: got %0d want 1", j, rsp_q.size() - r0);
         end else begin
            tests++; if (rsp_q[r0].prod !== vp[j]) begin fails++; $display("FAIL extreme_prod[%0d]: got %h want %h", j, rsp_q[r0].prod, vp[j]); end
            tests++; if (rsp_q[r0].vec !== want) begin fails++; $display("FAIL extreme_vec[%0d]: got %b want %b", j, rsp_q[r0].vec, want); end
         end
      end
   endtask

   task automatic test_round_robin();
      int rr_ord [5] = '{0, 1, 2, 3, 0};
      logic [7:0] rr_exp [4] = '{8'h02, 8'hF4, 8'hE2, 8'h07};
      int h0, r0;
      do_reset();
      h0 = hs_q.size(); r0 = rsp_q.size();
      set_req(0, 4'h1, 4'h2);
      set_req(1, 4'hD, 4'h4);
      set_req(2, 4'h5, 4'hA);
      set_req(3, 4'h9, 4'hF);
      for (int k = 0; k < 200 && hs_q.size() < h0 + 5; k++) @(negedge clk);
      @(posedge clk);
      #1;
      bus.req_valid = '0;
      repeat (20) tick();
      tests++;
      if (hs_q.size() != h0 + 5 || rsp_q.size() != r0 + 5) begin
         fails++; $display("FAIL rr_counts: got hs=%0d rsp=%0d want 5 5", hs_q.size() - h0, rsp_q.size() - r0);
      end else begin
         for (int j = 0; j < 5; j++) begin
            logic [N-1:0] want;
            want = '0;
            want[rr_ord[j]] = 1'b1;
            tests++; if (hs_q[h0+j].idx != rr_ord[j]) begin fails++; $display("FAIL rr_order[%0d]: got %0d want %0d", j, hs_q[h0+j].idx, rr_ord[j]); end
            if (j > 0) begin
               tests++; if (hs_q[h0+j].ed - hs_q[h0+j-1].ed != 18) begin fails++; $display("FAIL rr_period[%0d]: got %0d want 18", j, hs_q[h0+j].ed - hs_q[h0+j-1].ed); end
            end
            tests++; if (rsp_q[r0+j].vec !== want) begin fails++; $display("FAIL rr_vec[%0d]: got %b want %b", j, rsp_q[r0+j].vec, want); end
            tests++; if (rsp_q[r0+j].prod !== rr_exp[rr_ord[j]]) begin fails++; $display("FAIL rr_prod[%0d]: got %h want %h", j, rsp_q[r0+j].prod, rr_exp[rr_ord[j]]); end
            tests++; if (rsp_q[r0+j].ed - hs_q[h0+j].ed != 16) begin fails++; $display("FAIL rr_latency[%0d]: got %0d want 16", j, rsp_q[r0+j].ed - hs_q[h0+j].ed); end
         end
      end
   endtask

   task automatic test_pointer();
      int h0;
      do_reset();
      h0 = hs_q.size();
      set_req(2, 4'd2, 4'd2);
      serve_one();
      repeat (20) tick();
      set_req(1, 4'd1, 4'd1);
      set_req(3, 4'd3, 4'd3);
      serve_one();
      serve_one();
      repeat (20) tick();
      tests++;
      if (hs_q.size() != h0 + 3) begin
         fails++; $display("FAIL ptr_counts: got %0d want 3", hs_q.size() - h0);
      end else begin
         tests++; if (hs_q[h0].idx != 2) begin fails++; $display("FAIL ptr_first: got %0d want 2", hs_q[h0].idx); end
         tests++; if (hs_q[h0+1].idx != 3) begin fails++; $display("FAIL ptr_second: got %0d want 3", hs_q[h0+1].idx); end
         tests++; if (hs_q[h0+2].idx != 1) begin fails++; $display("FAIL ptr_third: got %0d want 1", hs_q[h0+2].idx); end
      end
      do_reset();
      h0 = hs_q.size();
      set_req(1, 4'd1, 4'd1);
      set_req(3, 4'd3, 4'd3);
      #1;
      tests++; if (bus.req_ready !== 4'b0010) begin fails++; $display("FAIL ptr_after_reset_ready: got %b want 0010", bus.req_ready); end
      serve_one();
      bus.req_valid = '0;
      repeat (20) tick();
      tests++;
      if (hs_q.size() != h0 + 1) begin
         fails++; $display("FAIL ptr_after_reset_count: got %0d want 1", hs_q.size() - h0);
      end else begin
         tests++; if (hs_q[h0].idx != 1) begin fails++; $display("FAIL ptr_after_reset_idx: got %0d want 1", hs_q[h0].idx); end
      end
   endtask

   task automatic test_withdraw();
      int h0, r0;
      h0 = hs_q.size(); r0 = rsp_q.size();
      set_req(0, 4'd2, 4'd3);
      serve_one();
      tick();
      tick();
      bus.req_a[3:0] = 4'h7;
      bus.req_b[3:0] = 4'h7;
      set_req(1, 4'd5, 4'd5);
      repeat (5) tick();
      bus.req_valid[1] = 1'b0;
      repeat (3) tick();
      tests++; if (bus.mpy_a !== 4'd2) begin fails++; $display("FAIL withdraw_mpy_a: got %h want 2", bus.mpy_a); end
      tests++; if (bus.mpy_b !== 4'd3) begin fails++; $display("FAIL withdraw_mpy_b: got %h want 3", bus.mpy_b); end
      repeat (15) tick();
      tests++; if (hs_q.size() != h0 + 1) begin fails++; $display("FAIL withdraw_hs_count: got %0d want 1", hs_q.size() - h0); end
      tests++;
      if (rsp_q.size() != r0 + 1) begin
         fails++; $display("FAIL withdraw_rsp_count: got %0d want 1", rsp_q.size() - r0);
      end else begin
         tests++; if (rsp_q[r0].vec !== 4'b0001) begin fails++; $display("FAIL withdraw_vec: got %b want 0001", rsp_q[r0].vec); end
         tests++; if (rsp_q[r0].prod !== 8'h06) begin fails++; $display("FAIL withdraw_prod: got %h want 06", rsp_q[r0].prod); end
      end
   endtask

   task automatic test_reset_mid();
      int h0, r0;
      r0 = rsp_q.size();
      set_req(2, 4'hC, 4'd3);
      serve_one();
      repeat (5) tick();
      #3;
      rst = 1'b1;
      #1;
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
      tests++; if (bus.mpy_a !== 4'h0) begin fails++; $display("FAIL midrst_mpy_a: got %h want 0", bus.mpy_a); end
      tests++; if (bus.mpy_b !== 4'h0) begin fails++; $display("FAIL midrst_mpy_b: got %h want 0", bus.mpy_b); end
      tests++; if (bus.resp_product !== 8'h00) begin fails++; $display("FAIL midrst_resp_product: got %h want 00", bus.resp_product); end
      tests++; if (bus.resp_valid !== 4'b0000) begin fails++; $display("FAIL midrst_resp_valid: got %b want 0000", bus.resp_valid); end
      tick();
      rst = 1'b0;
      repeat (20) tick();
      tests++; if (rsp_q.size() != r0) begin fails++; $display("FAIL midrst_no_resp: got %0d want 0", rsp_q.size() - r0); end
      h0 = hs_q.size(); r0 = rsp_q.size();
      set_req(3, 4'd6, 4'hD);
      serve_one();
      repeat (20) tick();
      tests++;
      if (hs_q.size() != h0 + 1 || rsp_q.size() != r0 + 1) begin
         fails++; $display("FAIL midrst_fresh_counts: got hs=%0d rsp=%0d want 1 1", hs_q.size() - h0, rsp_q.size() - r0);
      end else begin
         tests++; if (hs_q[h0].idx != 3) begin fails++; $display("FAIL midrst_fresh_idx: got %0d want 3", hs_q[h0].idx); end
         tests++; if (rsp_q[r0].vec !== 4'b1000) begin fails++; $display("FAIL midrst_fresh_vec: got %b want 1000", rsp_q[r0].vec); end
         tests++; if (rsp_q[r0].prod !== 8'hEE) begin fails++; $display("FAIL midrst_fresh_prod: got %h want ee", rsp_q[r0].prod); end
         tests++; if (rsp_q[r0].ed - hs_q[h0].ed != 16) begin fails++; $display("FAIL midrst_fresh_latency: got %0d want 16", rsp_q[r0].ed - hs_q[h0].ed); end
      end
   endtask

   initial begin
      bus.req_valid = '0;
      bus.req_a = '0;
      bus.req_b = '0;
      test_reset();
      test_single();
      test_extremes();
      test_round_robin();
      test_pointer();
      test_withdraw();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mpy_share_ctrl.md
# mpy_share_ctrl

Round-robin scheduler that shares one sequential 4-bit signed multiplier (`MPY`, operands held stable for a fixed number of cycles before `product` is valid) among several requesters. Each requester hands over a signed operand pair with a valid/ready handshake. The controller drives the multiplier's `a`/`b` inputs, counts out the multiplier latency, samples `product`, and returns it to the granted requester as a one-cycle response pulse. It sits between the requesting datapath blocks and the single `MPY` instance, which is instantiated outside this block.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `MPY_LAT`, default 16: cycles operands must be held before `mpy_product` is sampled, ≥ 1.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `req_valid` in N_REQ: per-requester request.
- `req_a` in 4*N_REQ: signed operand a, requester i in bits [4i+3:4i].
- `req_b` in 4*N_REQ: signed operand b, same packing.
- `req_ready` out N_REQ: one-hot grant. Combinational from state, pointer and `req_valid`.
- `mpy_a` out 4: registered operand to `MPY.a`.
- `mpy_b` out 4: registered operand to `MPY.b`.
- `mpy_product` in 8: signed product from `MPY`.
- `resp_valid` out N_REQ: one-hot, one-cycle pulse, registered.
- `resp_product` out 8: signed result. Valid while any `resp_valid` bit is high; holds its value otherwise.
- `busy` out 1: high in WAIT and DONE.

## Operation
- States are IDLE, WAIT and DONE. Internal registers:
  - `ptr` (priority pointer, log2 N_REQ bits)
  - `gnt` (index of the granted requester)
  - `cnt` (counter, wide enough for MPY_LAT-1)
- **IDLE.**
  - Winner g is the first i with `req_valid[i]` high, searching ptr, ptr+1, … mod N_REQ.
  - `req_ready[g]` = 1 combinationally; all other bits are 0.
  - With no request, `req_ready` = 0.
  - On the edge where the handshake fires: `mpy_a` ← `req_a[g]`, `mpy_b` ← `req_b[g]`, `gnt` ← g, `cnt` ← MPY_LAT-1, `ptr` ← (g+1) mod N_REQ, state → WAIT.
- **WAIT.**
  - `req_ready` = 0. `cnt` decrements each edge.
  - On the edge where `cnt` == 0: `resp_product` ← `mpy_product`, `resp_valid[gnt]` ← 1, state → DONE.
- **DONE.**
  - `req_ready` = 0.
  - Next edge: `resp_valid` ← 0, state → IDLE.
- `mpy_a`/`mpy_b` change only on a handshake edge, and hold the last operands between operations.
- No arithmetic is done here. `resp_product` is `mpy_product` unmodified, interpreted as signed 8-bit (range −56..64).
- A requester may drop `req_valid` at any time before its handshake. No grant is issued for a dropped request.
- Operands are captured only on the handshake edge. Later changes to `req_a`/`req_b` have no effect.
- There is no response backpressure. A requester must accept its `resp_valid` pulse.
- Reset state (asynchronous): state IDLE, `ptr` = 0, `gnt` = 0, `cnt` = 0, `mpy_a` = 0, `mpy_b` = 0, `resp_product` = 0, `resp_valid` = 0, `busy` = 0.
- Reset asserted in WAIT or DONE aborts the operation. No `resp_valid` is issued for it, and the next post-reset arbitration starts from requester 0.

## Timing
- Handshake at edge T. `mpy_a`/`mpy_b` are valid from just after T.
- `mpy_product` is sampled at edge T+MPY_LAT.
- `resp_valid` is high between edges T+MPY_LAT and T+MPY_LAT+1.
- Back in IDLE after T+MPY_LAT+1, so the next handshake is at edge T+MPY_LAT+2 at the earliest.
- Throughput: one product per MPY_LAT+2 cycles.
- With MPY_LAT=16: 18-cycle period, response 16 cycles after the grant edge.
- Worst-case wait for a continuously requesting client: (N_REQ-1)·(MPY_LAT+2) cycles after the current operation ends.
- `busy` rises on edge T and falls on edge T+MPY_LAT+1.

## Test plan
- **Single request.** Requester 0 asserts `req_valid` with a=3, b=−2.
  - Handshake on the first edge.
  - `resp_valid[0]` one cycle, 16 cycles later, with `resp_product` = −6.
  - `busy` high for 17 cycles.
- **Signed extremes.**
  - a=−8, b=−8 → 64.
  - a=−8, b=7 → −56.
  - a=7, b=7 → 49.
  - a=0, b=−5 → 0.
- **Round robin.** All four requesters hold `req_valid` continuously with distinct operands.
  - Grant order is 0,1,2,3,0.
  - Handshakes are 18 cycles apart.
  - Each `resp_valid[i]` pulse carries requester i's product.
- **Pointer rotation.**
  - Requester 2 is served first; then requesters 1 and 3 request together → 3 is granted before 1.
  - After reset, requesters 1 and 3 request together → 1 is granted first.
- **Withdrawn request.**
  - While requester 0 is being served, requester 1 raises then drops `req_valid` before IDLE → no handshake and no `resp_valid[1]`.
  - Operand changes on requester 0 after its handshake → `mpy_a`/`mpy_b` unchanged.
- **Reset mid-operation.**
  - `rst` pulsed 5 cycles into WAIT → all outputs return to reset values immediately, and no `resp_valid` appears.
  - A fresh request afterward completes normally in 16 cycles.
